// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// Imported by the arbiter top level and the busy-bit scoreboard.
package rf_pkg;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;

    localparam logic [AW-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_A,
        GNT_B
    } grant_t;

endpackage

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Busy-bit scoreboard for destination registers with writes in flight.
// Issue sets a bit, the registered write clears it; set beats clear.
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          set_en,
    input  logic [AW-1:0] set_rd,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_rd,
    input  logic [AW-1:0] issue_rd,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    output logic          issue_ok,
    output logic          hazard1,
    output logic          hazard2
);

    logic [NREG-1:0] busy;

    // Later assignment wins, so a same-cycle set overrides the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (clr_en) begin
                busy[clr_rd] <= 1'b0;
            end
            if (set_en && (set_rd != REG_ZERO)) begin
                busy[set_rd] <= 1'b1;
            end
            busy[REG_ZERO] <= 1'b0;
        end
    end

    assign issue_ok = ~busy[issue_rd];
    assign hazard1  = busy[rs1];
    assign hazard2  = busy[rs2];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between
// the ALU (A) and load unit (B), with a registered write stage.
module regfile_wb_arbiter
    import rf_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          a_valid,
    input  logic [AW-1:0] a_rd,
    input  logic [DW-1:0] a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [AW-1:0] b_rd,
    input  logic [DW-1:0] b_data,
    output logic          b_ready,
    input  logic          issue_en,
    input  logic [AW-1:0] issue_rd,
    output logic          issue_ok,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    output logic          hazard1,
    output logic          hazard2,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data
);

    grant_t        gnt;
    logic          prio;
    logic          both;
    logic          do_wr;
    logic [AW-1:0] sel_rd;
    logic [DW-1:0] sel_data;

    assign both = a_valid & b_valid;

    // prio=0 favours A on contention, prio=1 favours B.
    always_comb begin
        gnt = GNT_NONE;
        if (!rst) begin
            unique case (1'b1)
                both:                gnt = prio ? GNT_B : GNT_A;
                a_valid & ~b_valid:  gnt = GNT_A;
                ~a_valid & b_valid:  gnt = GNT_B;
                default:             gnt = GNT_NONE;
            endcase
        end
    end

    assign a_ready = (gnt == GNT_A);
    assign b_ready = (gnt == GNT_B);

    always_comb begin
        sel_rd   = a_rd;
        sel_data = a_data;
        if (gnt == GNT_B) begin
            sel_rd   = b_rd;
            sel_data = b_data;
        end
    end

    // x0 requests are consumed but never reach the register file.
    assign do_wr = (gnt != GNT_NONE) && (sel_rd != REG_ZERO);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            prio    <= 1'b0;
        end else begin
            wr_en <= do_wr;
            if (do_wr) begin
                wr_addr <= sel_rd;
                wr_data <= sel_data;
            end
            if (both) begin
                prio <= ~prio;
            end
        end
    end

    rf_scoreboard u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (issue_en),
        .set_rd   (issue_rd),
        .clr_en   (wr_en),
        .clr_rd   (wr_addr),
        .issue_rd (issue_rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .issue_ok (issue_ok),
        .hazard1  (hazard1),
        .hazard2  (hazard2)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed scenarios plus
// randomized traffic against a queue/array reference model.
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;
    import rf_pkg::*;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } req_t;

    typedef struct packed {
        logic          en;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_valid, b_valid, a_ready, b_ready;
    logic [AW-1:0] a_rd, b_rd, issue_rd, rs1, rs2, wr_addr;
    logic [DW-1:0] a_data, b_data, wr_data;
    logic          issue_en, issue_ok, hazard1, hazard2, wr_en;

    req_t aq[$];
    req_t bq[$];
    exp_t expq[$];

    bit            mbusy[NREG];
    bit            m_prio;
    logic          m_en;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
        .issue_en(issue_en), .issue_rd(issue_rd), .issue_ok(issue_ok),
        .rs1(rs1), .rs2(rs2), .hazard1(hazard1), .hazard2(hazard2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #50 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Decode never issues to a busy destination.
    always @(posedge clk) begin
        if (!rst && issue_en) begin
            assert (issue_ok)
            else $error("FAIL issue_waw: issue to busy x%0d", issue_rd);
        end
    end

    // Monitor: one expected write-port state per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("wr_en", 32'(wr_en), 32'(e.en));
                chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                chk("wr_data", wr_data, e.data);
            end
        end
    end

    // One cycle: present queued requests, check combinational outputs,
    // predict the next write-port state, advance the model past the edge.
    task automatic step();
        grant_t g;
        exp_t   e;
        a_valid = (aq.size() > 0);
        b_valid = (bq.size() > 0);
        a_rd    = a_valid ? aq[0].rd : '0;
        a_data  = a_valid ? aq[0].data : '0;
        b_rd    = b_valid ? bq[0].rd : '0;
        b_data  = b_valid ? bq[0].data : '0;
        #1;
        g = GNT_NONE;
        if (!rst) begin
            if (a_valid && b_valid) g = m_prio ? GNT_B : GNT_A;
            else if (a_valid)       g = GNT_A;
            else if (b_valid)       g = GNT_B;
        end
        chk("a_ready", 32'(a_ready), 32'(g == GNT_A));
        chk("b_ready", 32'(b_ready), 32'(g == GNT_B));
        chk("issue_ok", 32'(issue_ok), 32'(!mbusy[issue_rd]));
        chk("hazard1", 32'(hazard1), 32'(mbusy[rs1]));
        chk("hazard2", 32'(hazard2), 32'(mbusy[rs2]));
        e = '{en: 1'b0, addr: m_addr, data: m_data};
        if (rst)
            e = '0;
        else if (g == GNT_A && a_rd != 0)
            e = '{en: 1'b1, addr: a_rd, data: a_data};
        else if (g == GNT_B && b_rd != 0)
            e = '{en: 1'b1, addr: b_rd, data: b_data};
        expq.push_back(e);
        if (rst) begin
            foreach (mbusy[i]) mbusy[i] = 1'b0;
            m_prio = 1'b0;
        end else begin
            if (m_en) mbusy[m_addr] = 1'b0;
            if (issue_en && issue_rd != 0) mbusy[issue_rd] = 1'b1;
            if (a_valid && b_valid) m_prio = ~m_prio;
        end
        m_en   = e.en;
        m_addr = e.addr;
        m_data = e.data;
        if (g == GNT_A) void'(aq.pop_front());
        if (g == GNT_B) void'(bq.pop_front());
        @(posedge clk);
        #1;
        issue_en = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((aq.size() > 0 || bq.size() > 0) && n < budget) begin
            step();
            n++;
        end
        chk("drain_budget", 32'(aq.size() + bq.size()), 32'd0);
    endtask

    initial begin
        logic [AW-1:0] r;
        #100_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] r;
        rst = 1'b1;
        issue_en = 1'b0;
        issue_rd = '0;
        rs1 = '0;
        rs2 = '0;
        m_prio = 1'b0;
        m_en = 1'b0;
        m_addr = '0;
        m_data = '0;
        foreach (mbusy[i]) mbusy[i] = 1'b0;

        // Reset held two cycles while A requests.
        aq.push_back('{rd: 5'd3, data: 32'h0000_0033});
        step();
        step();
        for (int i = 0; i < NREG; i++) begin
            rs1 = AW'(i);
            rs2 = AW'(NREG - 1 - i);
            #1;
            chk("rst_hazard1", 32'(hazard1), 32'd0);
            chk("rst_hazard2", 32'(hazard2), 32'd0);
        end
        rs1 = '0;
        rs2 = '0;
        rst = 1'b0;
        step();

        // Single requester.
        aq.push_back('{rd: 5'd5, data: 32'hDEAD_BEEF});
        step();
        step();

        // Contention: expect writes 1, 9, 2, 10, ...
        for (int i = 0; i < 4; i++) begin
            aq.push_back('{rd: AW'(1 + i), data: $urandom});
            bq.push_back('{rd: AW'(9 + i), data: $urandom});
        end
        repeat (4) step();
        drain(8);

        // Scoreboard set and clear by a B write.
        rs1 = 5'd7;
        issue_rd = 5'd7;
        issue_en = 1'b1;
        step();
        step();
        step();
        bq.push_back('{rd: 5'd7, data: 32'h0700_0007});
        repeat (3) step();

        // Set/clear collision on x3.
        rs2 = 5'd3;
        aq.push_back('{rd: 5'd3, data: 32'h0300_0003});
        step();
        issue_rd = 5'd3;
        issue_en = 1'b1;
        step();
        step();
        aq.push_back('{rd: 5'd3, data: 32'h0300_0004});
        repeat (3) step();

        // x0 write is consumed but suppressed.
        rs1 = 5'd0;
        aq.push_back('{rd: 5'd0, data: 32'hFFFF_FFFF});
        step();
        step();

        // Reset while a write to x6 is in flight.
        rs1 = 5'd6;
        issue_rd = 5'd6;
        issue_en = 1'b1;
        aq.push_back('{rd: 5'd6, data: 32'h0600_0006});
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        step();

        // Randomized traffic.
        repeat (400) begin
            if ($urandom_range(3) == 0 && aq.size() < 3)
                aq.push_back('{rd: AW'($urandom_range(31)), data: $urandom});
            if ($urandom_range(3) == 0 && bq.size() < 3)
                bq.push_back('{rd: AW'($urandom_range(31)), data: $urandom});
            rs1 = AW'($urandom_range(31));
            rs2 = AW'($urandom_range(31));
            r = AW'($urandom_range(31));
            issue_rd = r;
            issue_en = ($urandom_range(2) == 0) && !mbusy[r];
            rst = ($urandom_range(96) == 0);
            step();
        end
        rst = 1'b0;
        drain(16);
        repeat (3) step();
        @(posedge clk);
        #3;
        chk("expq_empty", 32'(expq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
